// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and event layout for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] BYTE_E0     = 8'hE0;
  localparam logic [7:0] BYTE_F0     = 8'hF0;
  localparam logic [7:0] BYTE_E1     = 8'hE1;
  localparam logic [7:0] BYTE_LSHIFT = 8'h12;
  localparam logic [7:0] PAUSE_CODE  = 8'h77;
  localparam logic [2:0] PAUSE_SKIP  = 3'd6;
  localparam int         EV_W        = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_SKIP_PAUSE
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ev_t;

  // Keyboard housekeeping replies that never form part of a key event.
  function automatic logic isProtocol(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: isProtocol = 1'b1;
      default:                                         isProtocol = 1'b0;
    endcase
  endfunction

  function automatic logic isPrefix(input logic [7:0] b);
    isPrefix = (b == BYTE_E0) || (b == BYTE_F0) || (b == BYTE_E1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is always visible on rdata_o.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             popEff;
  logic             pushEff;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign popEff  = pop_i && !empty_o;
  assign pushEff = push_i && (!full_o || popEff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (pushEff) begin
        mem_q[wrPtr_q] <= wdata_i;
        wrPtr_q        <= wrPtr_q + AW'(1);
      end
      if (popEff) rdPtr_q <= rdPtr_q + AW'(1);
      if (pushEff && !popEff)      count_q <= count_q + CW'(1);
      else if (popEff && !pushEff) count_q <= count_q - CW'(1);
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns a raw PS/2 byte stream into {code, ext, rel} key events and queues them for the consumer.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES  = 2_500_000,
  parameter bit DROP_FAKE_SHIFT = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        byte_data,
  input  logic                              byte_valid,
  output logic [7:0]                        ev_code,
  output logic                              ev_ext,
  output logic                              ev_release,
  output logic                              ev_valid,
  input  logic                              ev_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              seq_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic [2:0]    skipCnt_q, skipCnt_d;
  logic [TW-1:0] tmoCnt_q, tmoCnt_d;
  logic          emit_q, emit_d;
  ev_t           emitEv_q, emitEv_d;
  logic          seqErr_q, seqErr_d;
  logic          overflow_q;
  logic          reprocess;

  logic [EV_W-1:0] headRaw;
  ev_t             head;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            popReq;

  // Next-state decode; a misplaced prefix flags an error and then restarts the sequence.
  always_comb begin
    state_d   = state_q;
    skipCnt_d = skipCnt_q;
    tmoCnt_d  = tmoCnt_q;
    emit_d    = 1'b0;
    emitEv_d  = '0;
    seqErr_d  = 1'b0;
    reprocess = 1'b0;
    if (byte_valid) begin
      tmoCnt_d = '0;
      unique case (state_q)
        ST_IDLE: reprocess = 1'b1;
        ST_GOT_E0: begin
          if (byte_data == BYTE_F0) begin
            state_d = ST_GOT_E0F0;
          end else if (DROP_FAKE_SHIFT && byte_data == BYTE_LSHIFT) begin
            state_d = ST_IDLE;
          end else if (byte_data == BYTE_E0 || byte_data == BYTE_E1) begin
            seqErr_d  = 1'b1;
            reprocess = 1'b1;
          end else begin
            emit_d   = 1'b1;
            emitEv_d = '{ext: 1'b1, rel: 1'b0, code: byte_data};
            state_d  = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (isPrefix(byte_data)) begin
            seqErr_d  = 1'b1;
            reprocess = 1'b1;
          end else begin
            emit_d   = 1'b1;
            emitEv_d = '{ext: 1'b0, rel: 1'b1, code: byte_data};
            state_d  = ST_IDLE;
          end
        end
        ST_GOT_E0F0: begin
          if (DROP_FAKE_SHIFT && byte_data == BYTE_LSHIFT) begin
            state_d = ST_IDLE;
          end else if (isPrefix(byte_data)) begin
            seqErr_d  = 1'b1;
            reprocess = 1'b1;
          end else begin
            emit_d   = 1'b1;
            emitEv_d = '{ext: 1'b1, rel: 1'b1, code: byte_data};
            state_d  = ST_IDLE;
          end
        end
        ST_SKIP_PAUSE: begin
          if (skipCnt_q == 3'd0) begin
            emit_d   = 1'b1;
            emitEv_d = '{ext: 1'b1, rel: 1'b0, code: PAUSE_CODE};
            state_d  = ST_IDLE;
          end else begin
            skipCnt_d = skipCnt_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (reprocess) begin
        if (byte_data == BYTE_E0) begin
          state_d = ST_GOT_E0;
        end else if (byte_data == BYTE_F0) begin
          state_d = ST_GOT_F0;
        end else if (byte_data == BYTE_E1) begin
          state_d   = ST_SKIP_PAUSE;
          skipCnt_d = PAUSE_SKIP;
        end else if (isProtocol(byte_data)) begin
          state_d = ST_IDLE;
        end else begin
          emit_d   = 1'b1;
          emitEv_d = '{ext: 1'b0, rel: 1'b0, code: byte_data};
          state_d  = ST_IDLE;
        end
      end
    end else if (state_q != ST_IDLE) begin
      if (tmoCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d  = ST_IDLE;
        tmoCnt_d = '0;
        seqErr_d = 1'b1;
      end else begin
        tmoCnt_d = tmoCnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      skipCnt_q <= '0;
      tmoCnt_q  <= '0;
      emit_q    <= 1'b0;
      emitEv_q  <= '0;
      seqErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      skipCnt_q <= skipCnt_d;
      tmoCnt_q  <= tmoCnt_d;
      emit_q    <= emit_d;
      emitEv_q  <= emitEv_d;
      seqErr_q  <= seqErr_d;
    end
  end

  assign popReq = ev_ready && !fifoEmpty;

  // Sticky: only a reset clears a record of a lost event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else if (emit_q && fifoFull && !popReq) overflow_q <= 1'b1;
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (emit_q),
    .wdata_i (emitEv_q),
    .pop_i   (popReq),
    .rdata_o (headRaw),
    .count_o (fifo_count),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign head       = headRaw;
  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_release = head.rel;
  assign ev_valid   = !fifoEmpty;
  assign overflow   = overflow_q;
  assign seq_err    = seqErr_q;

endmodule
